// File: rtl/munoc_ahb2axi_pkg.sv
// Shared types and constants for the MUNOC AHB-Lite to AXI4 bridge.
// Optional posted-write mode is selected with MUNOC_AHB2AXI_WRITE_POST_EN.
package munoc_ahb2axi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RRESP = 3'd4,
    ERR1  = 3'd5,
    ERR2  = 3'd6
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AHB hprot[0]=data, hprot[1]=privileged; AXI prot[2]=instruction,
  // prot[1]=non-secure, prot[0]=privileged.
  function automatic logic [2:0] ahb_to_axi_prot(input logic [3:0] hprot);
    return {~hprot[0], 1'b1, hprot[1]};
  endfunction

endpackage

// File: rtl/munoc_ahb_wstrb_gen.sv
// Byte-lane strobe generator: naturally aligned lanes from transfer size and
// the low address bits.
module munoc_ahb_wstrb_gen #(
  parameter int BW_DATA = 32
) (
  input  logic [2:0]                     hsize,
  input  logic [$clog2(BW_DATA/8)-1:0]   addr,
  output logic [BW_DATA/8-1:0]           wstrb
);

  localparam int NB = BW_DATA / 8;

  // A lane is enabled when it lies in the same size-aligned block as addr.
  always_comb begin
    wstrb = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >> hsize) == (int'(addr) >> hsize)) wstrb[i] = 1'b1;
    end
  end

endmodule

// File: rtl/munoc_ahb2axi_bridge.sv
// AHB-Lite slave to AXI4 master bridge: one single-beat AXI transaction per AHB beat.
// Define MUNOC_AHB2AXI_WRITE_POST_EN to complete writes on AHB before the B response.
module munoc_ahb2axi_bridge
  import munoc_ahb2axi_pkg::*;
#(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int BW_AXI_TID = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  // AHB-Lite slave
  input  logic                    hsel,
  input  logic                    hwrite,
  input  logic                    hmastlock,
  input  logic                    hready,
  input  logic [BW_ADDR-1:0]      haddr,
  input  logic [1:0]              htrans,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [BW_DATA-1:0]      hwdata,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [BW_DATA-1:0]      hrdata,
  // AXI4 write address
  output logic [BW_AXI_TID-1:0]   awid,
  output logic [BW_ADDR-1:0]      awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI4 write data
  output logic [BW_DATA-1:0]      wdata,
  output logic [BW_DATA/8-1:0]    wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI4 write response
  input  logic [BW_AXI_TID-1:0]   bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AXI4 read address
  output logic [BW_AXI_TID-1:0]   arid,
  output logic [BW_ADDR-1:0]      araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI4 read data
  input  logic [BW_AXI_TID-1:0]   rid,
  input  logic [BW_DATA-1:0]      rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  // Status
  output logic                    post_err,
  output state_e                  dbg_state
);

  localparam int         BW_OFS   = $clog2(BW_DATA / 8);
  localparam logic [2:0] SIZE_MAX = 3'(BW_OFS);

  // Handshake rule for every AXI channel: a transfer happens in the cycle where
  // valid and ready are both high; valid never depends on ready and, once raised,
  // stays high until that transfer or an asynchronous reset.

  state_e               state_q, state_d;
  logic [BW_ADDR-1:0]   addr_q;
  logic [2:0]           hsize_q;
  logic [3:0]           hprot_q;
  logic                 aw_done_q, w_done_q;
  logic                 aw_hs, w_hs;
  logic                 accept, sample, size_bad;
  logic                 b_pend_q;
  logic                 unused_inputs;

  assign accept   = (state_q == IDLE) || (state_q == ERR2);
  assign sample   = accept & hsel & hready & htrans[1];
  assign size_bad = (hsize > SIZE_MAX);

  assign unused_inputs = ^{hmastlock, hburst, htrans[0], bid, rid, rlast};

`ifdef MUNOC_AHB2AXI_WRITE_POST_EN
  logic post_err_q;
  logic b_hs;

  assign b_hs = bvalid & bready;

  // One posted write may wait for its B; new AXI requests hold off until it lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_pend_q   <= 1'b0;
      post_err_q <= 1'b0;
    end else begin
      if (b_hs) b_pend_q <= 1'b0;
      else if (state_q == WRITE && state_d == IDLE) b_pend_q <= 1'b1;
      if (b_hs && bresp[1]) post_err_q <= 1'b1;
    end
  end

  assign post_err = post_err_q;
`else
  assign b_pend_q = 1'b0;
  assign post_err = 1'b0;
`endif

  // AXI request channels
  assign awid    = '0;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = hsize_q;
  assign awburst = AXI_BURST_INCR;
  assign awprot  = ahb_to_axi_prot(hprot_q);
  assign awvalid = (state_q == WRITE) & ~aw_done_q & ~b_pend_q;

  assign wdata   = hwdata;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == WRITE) & ~w_done_q & ~b_pend_q;

  assign bready  = (state_q == WRESP) | b_pend_q;

  assign arid    = '0;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = hsize_q;
  assign arburst = AXI_BURST_INCR;
  assign arprot  = ahb_to_axi_prot(hprot_q);
  assign arvalid = (state_q == READ) & ~b_pend_q;

  assign rready  = (state_q == RRESP);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  assign dbg_state = state_q;

  munoc_ahb_wstrb_gen #(
    .BW_DATA (BW_DATA)
  ) u_wstrb_gen (
    .hsize (hsize_q),
    .addr  (addr_q[BW_OFS-1:0]),
    .wstrb (wstrb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      hsize_q   <= '0;
      hprot_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      hrdata    <= '0;
    end else begin
      state_q <= state_d;
      if (sample) begin
        addr_q  <= haddr;
        hsize_q <= hsize;
        hprot_q <= hprot;
      end
      // AW and W complete independently; remember which one is already done.
      if (state_q == WRITE && state_d == WRITE) begin
        aw_done_q <= aw_done_q | aw_hs;
        w_done_q  <= w_done_q | w_hs;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (rvalid && rready) hrdata <= rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state_q)
      IDLE, ERR2: begin
        if (state_q == ERR2) hresp = HRESP_ERROR;
        if (sample) begin
          if (size_bad)    state_d = ERR1;
          else if (hwrite) state_d = WRITE;
          else             state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        hreadyout = 1'b0;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
`ifdef MUNOC_AHB2AXI_WRITE_POST_EN
          state_d = IDLE;
`else
          state_d = WRESP;
`endif
        end
      end
      WRESP: begin
        hreadyout = 1'b0;
        if (bvalid) state_d = bresp[1] ? ERR1 : IDLE;
      end
      READ: begin
        hreadyout = 1'b0;
        if (arvalid && arready) state_d = RRESP;
      end
      RRESP: begin
        hreadyout = 1'b0;
        if (rvalid) state_d = (rresp == AXI_RESP_OKAY) ? IDLE : ERR1;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ERR2;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
